// File: rtl/sde_frame_ctrl.sv
// Frame sequencer for the serial "10010" status detector: flush preamble,
// MSB-first byte serialisation and per-frame hit counting.
module sde_frame_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DET_LAT   = 1,
    parameter int unsigned FLUSH_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             ser_bit,
    input  logic             det_hit,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             ovf,
    output logic             err,
    output logic             frm_done
);

    localparam int unsigned FL_W = (FLUSH_LEN > 2) ? $clog2(FLUSH_LEN) : 1;
    localparam int unsigned DL_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [7:0]         sreg;
    logic               last_q;
    logic [2:0]         bit_idx;
    logic [FL_W-1:0]    flush_cnt;
    logic [DL_W-1:0]    drain_cnt;
    logic [DET_LAT-1:0] fb_pipe;

    logic take;
    logic in_shift;
    logic count_en;
    logic cnt_max;

    assign take     = s_valid && s_ready;
    assign in_shift = (state == SHIFT);
    // A hit belongs to the frame only if the bit that completed it was a frame bit.
    assign count_en = det_hit && fb_pipe[DET_LAT-1];
    assign cnt_max  = &hit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= 8'd0;
            last_q    <= 1'b0;
            bit_idx   <= 3'd0;
            flush_cnt <= '0;
            drain_cnt <= '0;
            fb_pipe   <= '0;
            s_ready   <= 1'b0;
            ser_bit   <= 1'b0;
            busy      <= 1'b0;
            hit_cnt   <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            frm_done  <= 1'b0;
        end else begin
            frm_done   <= 1'b0;
            fb_pipe[0] <= in_shift;
            for (int i = 1; i < int'(DET_LAT); i++) begin
                fb_pipe[i] <= fb_pipe[i-1];
            end

            if (count_en) begin
                if (cnt_max) begin
                    ovf <= 1'b1;
                end else begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    ser_bit <= 1'b0;
                    busy    <= 1'b0;
                    if (take) begin
                        sreg      <= s_data;
                        last_q    <= s_last;
                        hit_cnt   <= '0;
                        ovf       <= 1'b0;
                        err       <= 1'b0;
                        flush_cnt <= '0;
                        s_ready   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= FLUSH;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end

                FLUSH: begin
                    s_ready <= 1'b0;
                    if (flush_cnt == FL_W'(FLUSH_LEN - 1)) begin
                        bit_idx <= 3'd7;
                        ser_bit <= sreg[7];
                        state   <= SHIFT;
                    end else begin
                        ser_bit   <= 1'b0;
                        flush_cnt <= flush_cnt + FL_W'(1);
                    end
                end

                SHIFT: begin
                    if (bit_idx != 3'd0) begin
                        bit_idx <= bit_idx - 3'd1;
                        ser_bit <= sreg[bit_idx - 3'd1];
                        s_ready <= (bit_idx == 3'd1) && !last_q;
                    end else begin
                        s_ready <= 1'b0;
                        if (last_q) begin
                            ser_bit   <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else if (s_valid) begin
                            // Seamless reload: next byte's MSB follows without a gap bit.
                            sreg    <= s_data;
                            last_q  <= s_last;
                            bit_idx <= 3'd7;
                            ser_bit <= s_data[7];
                        end else begin
                            err       <= 1'b1;
                            ser_bit   <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    ser_bit <= 1'b0;
                    s_ready <= 1'b0;
                    if (drain_cnt == DL_W'(DET_LAT - 1)) begin
                        frm_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DL_W'(1);
                    end
                end

                DONE: begin
                    ser_bit <= 1'b0;
                    busy    <= 1'b0;
                    s_ready <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    ser_bit <= 1'b0;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sde_frame_ctrl.sv
// Directed bench for sde_frame_ctrl driving a behavioural overlapping "10010" detector.
module tb_sde_frame_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready,  s_ready2;
    logic        ser_bit,  ser_bit2;
    logic        det_hit,  det_hit2;
    logic        busy,     busy2;
    logic [15:0] hit_cnt;
    logic [1:0]  hit_cnt2;
    logic        ovf,      ovf2;
    logic        err,      err2;
    logic        frm_done, frm_done2;

    logic [4:0]  hist, hist2;
    int          cyc;
    int          errors;
    int          checks;
    int          k, k1, d;

    sde_frame_ctrl #(.CNT_W(16), .DET_LAT(1), .FLUSH_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .ser_bit(ser_bit), .det_hit(det_hit), .busy(busy),
        .hit_cnt(hit_cnt), .ovf(ovf), .err(err), .frm_done(frm_done)
    );

    sde_frame_ctrl #(.CNT_W(2), .DET_LAT(1), .FLUSH_LEN(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready2), .ser_bit(ser_bit2), .det_hit(det_hit2), .busy(busy2),
        .hit_cnt(hit_cnt2), .ovf(ovf2), .err(err2), .frm_done(frm_done2)
    );

    // Behavioural S_D_E: one-cycle latency, overlapping match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= 5'd0;
            hist2 <= 5'd0;
        end else begin
            hist  <= {hist[3:0], ser_bit};
            hist2 <= {hist2[3:0], ser_bit2};
        end
    end
    assign det_hit  = (hist == 5'b10010);
    assign det_hit2 = (hist2 == 5'b10010);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic l, output int at);
        for (int i = 0; i < 60 && !s_ready; i++) @(negedge clk);
        check("ready_wait", 32'(s_ready), 32'd1);
        s_data  = b;
        s_last  = l;
        s_valid = 1'b1;
        at      = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            if (frm_done) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        cyc     = 0;
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        s_data  = 8'd0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_busy",     32'(busy),     32'd0);
        check("rst_ser_bit",  32'(ser_bit),  32'd0);
        check("rst_s_ready",  32'(s_ready),  32'd0);
        check("rst_frm_done", 32'(frm_done), 32'd0);
        check("rst_ovf",      32'(ovf),      32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_hit_cnt",  32'(hit_cnt),  32'd0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x92: two overlapping hits.
        send(8'h92, 1'b1, k);
        wait_done(d);
        check("t1_done_lat", 32'(d - k),   32'd14);
        check("t1_hit_cnt",  32'(hit_cnt), 32'd2);
        check("t1_ovf",      32'(ovf),     32'd0);
        check("t1_err",      32'(err),     32'd0);
        check("t1_hit_cnt2", 32'(hit_cnt2), 32'd2);
        @(negedge clk);
        check("t1_pulse_end", 32'(frm_done), 32'd0);
        check("t1_idle_busy", 32'(busy),     32'd0);
        check("t1_cnt_hold",  32'(hit_cnt),  32'd2);

        // 0x09 then 0x00: the match straddling the frame boundary is not counted.
        send(8'h09, 1'b1, k);
        wait_done(d);
        check("t2a_hit_cnt", 32'(hit_cnt), 32'd0);
        send(8'h00, 1'b1, k1);
        check("t2_b2b_accept", 32'(k1 - d), 32'd1);
        wait_done(d);
        check("t2b_done_lat", 32'(d - k1),  32'd14);
        check("t2b_hit_cnt",  32'(hit_cnt), 32'd0);
        @(negedge clk);

        // Two-byte contiguous frame; narrow counter saturates.
        send(8'h92, 1'b0, k);
        send(8'h92, 1'b1, k1);
        check("t3_slot",      32'(k1 - k),   32'd12);
        wait_done(d);
        check("t3_done_lat",  32'(d - k),    32'd22);
        check("t3_hit_cnt",   32'(hit_cnt),  32'd4);
        check("t3_ovf",       32'(ovf),      32'd0);
        check("t3_err",       32'(err),      32'd0);
        check("t3_hit_cnt2",  32'(hit_cnt2), 32'd3);
        check("t3_ovf2",      32'(ovf2),     32'd1);
        @(negedge clk);

        // Underrun at byte-0 slot; a late byte must not be consumed.
        send(8'h92, 1'b0, k);
        for (int i = 0; i < 30 && !s_ready; i++) @(negedge clk);
        check("t4_slot", 32'(cyc - k), 32'd12);
        @(negedge clk);
        s_data  = 8'h55;
        s_last  = 1'b1;
        s_valid = 1'b1;
        check("t4_late_rdy",  32'(s_ready),  32'd0);
        @(negedge clk);
        check("t4_done",      32'(frm_done), 32'd1);
        check("t4_done_lat",  32'(cyc - k),  32'd14);
        check("t4_err",       32'(err),      32'd1);
        check("t4_hit_cnt",   32'(hit_cnt),  32'd2);
        check("t4_done_rdy",  32'(s_ready),  32'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        check("t4_idle_busy", 32'(busy),     32'd0);
        check("t4_idle_rdy",  32'(s_ready),  32'd1);

        // Reset asserted mid-SHIFT after one hit has been counted.
        send(8'h92, 1'b1, k);
        repeat (10) @(negedge clk);
        check("t5_mid_cnt",   32'(hit_cnt), 32'd1);
        check("t5_mid_bit",   32'(ser_bit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",  32'(busy),    32'd0);
        check("t5_rst_bit",   32'(ser_bit), 32'd0);
        check("t5_rst_cnt",   32'(hit_cnt), 32'd0);
        check("t5_rst_rdy",   32'(s_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h92, 1'b1, k);
        wait_done(d);
        check("t5_done_lat",  32'(d - k),   32'd14);
        check("t5_hit_cnt",   32'(hit_cnt), 32'd2);
        check("t5_err",       32'(err),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
